// File: rtl/traffic_pkg.sv
// ============================================================================
//  Module  : traffic_pkg
//  Brief   : Lamp encodings, phase enum and lamp decode helper for the
//            intersection controller.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_WALK   = 2'd3
    } phase_t;

    // Only the served direction may leave RED, and only in GREEN/YELLOW.
    function automatic logic [2:0] lamp_of(input phase_t ph, input logic served);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        if (served && (ph == PH_GREEN))  lamp = LAMP_GREEN;
        if (served && (ph == PH_YELLOW)) lamp = LAMP_YELLOW;
        return lamp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
//  Module  : dwell_timer
//  Brief   : Loadable down-counter; expire flags a qualified tick at zero.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int               CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = tick_en && enable;
    assign expire = w_tick && (r_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= RESET_VAL;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (w_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ============================================================================
//  Module  : traffic_light_ctrl
//  Brief   : N-direction GREEN/YELLOW/ALL-RED sequencer with tick-timed dwell.
//            Define TRAFFIC_PED_EN to add the pedestrian WALK phase.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR      = 2,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick_en,
    input  logic                       enable,
    input  logic                       ped_req,
    output logic [3*NUM_DIR-1:0]       light,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [1:0]                 phase,
    output logic                       walk,
    output logic                       ped_ack
);

    localparam int               DIR_W      = $clog2(NUM_DIR);
    localparam logic [DIR_W-1:0] LAST_DIR   = DIR_W'(NUM_DIR - 1);
    localparam logic [CNT_W-1:0] GREEN_RLD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_RLD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_RLD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_RLD   = CNT_W'(WALK_TICKS - 1);

    phase_t               r_phase;
    phase_t               w_next_phase;
    logic [DIR_W-1:0]     r_dir;
    logic [DIR_W-1:0]     w_next_dir;
    logic [DIR_W-1:0]     w_dir_inc;
    logic [3*NUM_DIR-1:0] r_light;
    logic [3*NUM_DIR-1:0] w_next_light;
    logic                 w_expire;
    logic                 w_load;
    logic [CNT_W-1:0]     w_load_val;
    logic                 w_ped_go;

    dwell_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (ALLRED_RLD)
    ) u_dwell_timer (
        .clock    (clock),
        .reset    (reset),
        .tick_en  (tick_en),
        .enable   (enable),
        .load     (w_load),
        .load_val (w_load_val),
        .expire   (w_expire)
    );

    assign w_dir_inc = (r_dir == LAST_DIR) ? '0 : r_dir + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= PH_ALLRED;
            r_dir   <= LAST_DIR;
            r_light <= {NUM_DIR{LAMP_RED}};
        end else begin
            r_phase <= w_next_phase;
            r_dir   <= w_next_dir;
            r_light <= w_next_light;
        end
    end

    // The timer reloads with the next dwell on the same cycle the phase ends.
    always_comb begin
        w_next_phase = r_phase;
        w_next_dir   = r_dir;
        w_load       = 1'b0;
        w_load_val   = ALLRED_RLD;
        case (r_phase)
            PH_GREEN: begin
                if (w_expire) begin
                    w_next_phase = PH_YELLOW;
                    w_load       = 1'b1;
                    w_load_val   = YELLOW_RLD;
                end
            end
            PH_YELLOW: begin
                if (w_expire) begin
                    w_next_phase = PH_ALLRED;
                    w_load       = 1'b1;
                    w_load_val   = ALLRED_RLD;
                end
            end
            PH_ALLRED: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (w_ped_go) begin
                        w_next_phase = PH_WALK;
                        w_load_val   = WALK_RLD;
                    end else begin
                        w_next_phase = PH_GREEN;
                        w_next_dir   = w_dir_inc;
                        w_load_val   = GREEN_RLD;
                    end
                end
            end
`ifdef TRAFFIC_PED_EN
            PH_WALK: begin
                if (w_expire) begin
                    w_next_phase = PH_GREEN;
                    w_next_dir   = w_dir_inc;
                    w_load       = 1'b1;
                    w_load_val   = GREEN_RLD;
                end
            end
`endif
            default: begin
                w_next_phase = PH_ALLRED;
                w_load       = 1'b1;
                w_load_val   = ALLRED_RLD;
            end
        endcase
    end

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_lamp
        assign w_next_light[3*d +: 3] = lamp_of(w_next_phase, w_next_dir == DIR_W'(d));
    end

`ifdef TRAFFIC_PED_EN
    logic r_ped_pend;
    logic r_ped_ack;
    logic r_walk;
    logic w_ped_accept;

    assign w_ped_accept = ped_req && !r_ped_pend && (r_phase != PH_WALK);
    assign w_ped_go     = r_ped_pend;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ped_pend <= 1'b0;
            r_ped_ack  <= 1'b0;
            r_walk     <= 1'b0;
        end else begin
            r_ped_ack <= w_ped_accept;
            r_walk    <= (w_next_phase == PH_WALK);
            if ((w_next_phase == PH_WALK) && (r_phase != PH_WALK)) begin
                r_ped_pend <= 1'b0;
            end else if (w_ped_accept) begin
                r_ped_pend <= 1'b1;
            end
        end
    end

    assign walk    = r_walk;
    assign ped_ack = r_ped_ack;
`else
    logic w_unused_ped_req;

    assign w_unused_ped_req = ped_req;
    assign w_ped_go         = 1'b0;
    assign walk             = 1'b0;
    assign ped_ack          = 1'b0;
`endif

    assign light      = r_light;
    assign active_dir = r_dir;
    assign phase      = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ============================================================================
//  Module  : tb_traffic_light_ctrl
//  Brief   : Random-stimulus bench against a phase-schedule reference model.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl;

    localparam int ND = 3;
    localparam int CW = 3;
    localparam int GT = 8;
    localparam int YT = 3;
    localparam int AT = 2;
    localparam int WT = 4;
    localparam int DW = $clog2(ND);
`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            tick_en;
    logic            enable;
    logic            ped_req;
    logic [3*ND-1:0] light;
    logic [DW-1:0]   active_dir;
    logic [1:0]      phase;
    logic            walk;
    logic            ped_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current phase/direction and ticks already spent in that phase.
    int m_phase, m_dir, m_used, m_pend, m_ack;

    traffic_light_ctrl #(
        .NUM_DIR      (ND),
        .CNT_W        (CW),
        .GREEN_TICKS  (GT),
        .YELLOW_TICKS (YT),
        .ALLRED_TICKS (AT),
        .WALK_TICKS   (WT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick_en    (tick_en),
        .enable     (enable),
        .ped_req    (ped_req),
        .light      (light),
        .active_dir (active_dir),
        .phase      (phase),
        .walk       (walk),
        .ped_ack    (ped_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int dwell(input int ph);
        case (ph)
            0:       return GT;
            1:       return YT;
            2:       return AT;
            default: return WT;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 2;
        m_dir   = ND - 1;
        m_used  = 0;
        m_pend  = 0;
        m_ack   = 0;
    endtask

    task automatic model_step(input bit te, input bit en, input bit pr);
        int old_pend;
        old_pend = m_pend;
        m_ack    = 0;
        if (PED_EN && pr && (m_pend == 0) && (m_phase != 3)) begin
            m_pend = 1;
            m_ack  = 1;
        end
        if (te && en) begin
            if (m_used + 1 == dwell(m_phase)) begin
                m_used = 0;
                case (m_phase)
                    0: m_phase = 1;
                    1: m_phase = 2;
                    2: begin
                        if (old_pend != 0) begin
                            m_phase = 3;
                            m_pend  = 0;
                        end else begin
                            m_phase = 0;
                            m_dir   = (m_dir + 1) % ND;
                        end
                    end
                    default: begin
                        m_phase = 0;
                        m_dir   = (m_dir + 1) % ND;
                    end
                endcase
            end else begin
                m_used++;
            end
        end
    endtask

    task automatic compare_all();
        logic [3*ND-1:0] exp_light;
        int              nonred;
        nonred = 0;
        for (int d = 0; d < ND; d++) begin
            exp_light[3*d +: 3] = 3'b100;
            if (d == m_dir && m_phase == 0) exp_light[3*d +: 3] = 3'b010;
            if (d == m_dir && m_phase == 1) exp_light[3*d +: 3] = 3'b001;
            if (light[3*d +: 3] != 3'b100) nonred++;
        end
        check("light", 32'(light), 32'(exp_light));
        check("phase", 32'(phase), 32'(m_phase));
        check("active_dir", 32'(active_dir), 32'(m_dir));
        check("walk", 32'(walk), 32'(m_phase == 3));
        check("ped_ack", 32'(ped_ack), 32'(m_ack));
        check("one_nonred", 32'(nonred <= 1), 32'd1);
    endtask

    task automatic step(input bit te, input bit en, input bit pr);
        tick_en = te;
        enable  = en;
        ped_req = pr;
        model_step(te, en, pr);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        reset   = 1'b1;
        tick_en = 1'b0;
        enable  = 1'b0;
        ped_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        reset = 1'b0;

        // Free-running ticks with occasional pedestrian pulses.
        repeat (120) step(1'b1, 1'b1, $urandom_range(0, 19) == 0);

        // Sparse ticks, random enable drop-outs.
        repeat (400) step($urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 29) == 0);

        // Tick every 4th cycle with a 10-cycle freeze in the middle.
        for (int i = 0; i < 200; i++) step((i % 4) == 0, !(i >= 50 && i < 60), 1'b0);

        // Walk into GREEN, then hit the asynchronous reset between edges.
        for (int k = 0; k < 100 && !(m_phase == 0 && m_used == 3); k++) step(1'b1, 1'b1, 1'b0);
        tick_en = 1'b1;
        enable  = 1'b1;
        reset   = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clock);
        compare_all();
        reset = 1'b0;

        // Heavy, often-held pedestrian requests.
        repeat (150) step(1'b1, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
